// File: rtl/button_event_fifo.sv
// Timestamped button-press event FIFO behind a 4-word Avalon-MM slave, with a level interrupt.
// Events with a full FIFO are dropped and counted unless a DATA read pops in the same cycle.
module button_event_fifo #(
  parameter int NUM_BTN  = 4,
  parameter int DEPTH    = 8,
  parameter int TS_WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_pulse,
  input  logic [1:0]         avs_address,
  input  logic               avs_read,
  input  logic               avs_write,
  input  logic [31:0]        avs_writedata,
  output logic [31:0]        avs_readdata,
  output logic               irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = NUM_BTN + TS_WIDTH;

  logic [EW-1:0]       mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [TS_WIDTH-1:0] ts_q, ts_d;
  logic                overflow_q, overflow_d;
  logic [7:0]          drop_cnt_q, drop_cnt_d;
  logic                irq_en_q, irq_en_d;
  logic                irq_q, irq_d;
  logic [31:0]         rdata_q, rdata_d;

  logic                empty, full, ev, pop, push, drop, flush, ctrl_wr;
  logic [EW-1:0]       head;
  logic [7:0]          mask_ext;
  logic [15:0]         head_ts_ext, time_ext;
  logic [6:0]          fill_ext;
  logic                unused_wdata;

  assign unused_wdata = ^avs_writedata[31:2];

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign ev      = |btn_pulse;
  assign ctrl_wr = avs_write && (avs_address == 2'd2);
  assign flush   = ctrl_wr && avs_writedata[1];
  assign pop     = avs_read && (avs_address == 2'd0) && !empty;
  // A same-cycle pop frees the slot, so a full FIFO still accepts the event.
  assign push    = ev && !flush && (!full || pop);
  assign drop    = ev && !flush && full && !pop;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mask_ext                  = '0;
    mask_ext[NUM_BTN-1:0]     = head[EW-1:TS_WIDTH];
    head_ts_ext               = '0;
    head_ts_ext[TS_WIDTH-1:0] = head[TS_WIDTH-1:0];
    time_ext                  = '0;
    time_ext[TS_WIDTH-1:0]    = ts_q;
    fill_ext                  = '0;
    fill_ext[CW-1:0]          = count_q;
  end

  always_comb begin
    ts_d       = ts_q + TS_WIDTH'(1);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    irq_en_d   = irq_en_q;
    if (ctrl_wr) irq_en_d = avs_writedata[0];
    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push) - CW'(pop);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
    irq_d = irq_en_d && (count_d != '0);
  end

  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        2'd0:    rdata_d = empty ? 32'h0 : {1'b1, 7'b0, mask_ext, head_ts_ext};
        2'd1:    rdata_d = {8'b0, drop_cnt_q, 5'b0, full, empty, overflow_q, 1'b0, fill_ext};
        2'd2:    rdata_d = {31'b0, irq_en_q};
        default: rdata_d = {16'b0, time_ext};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {btn_pulse, ts_q};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ts_q       <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      irq_en_q   <= 1'b0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ts_q       <= ts_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_button_event_fifo.sv
// Directed bench for button_event_fifo: inputs driven on falling edges, outputs sampled there too.
module tb_button_event_fifo;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  btn_pulse;
  logic [1:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  button_event_fifo #(.NUM_BTN(4), .DEPTH(8), .TS_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .btn_pulse(btn_pulse),
    .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
    .avs_writedata(avs_writedata), .avs_readdata(avs_readdata), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns the registered read data one cycle later.
  task automatic do_read(input logic [1:0] addr, output logic [31:0] data);
    avs_read    = 1'b1;
    avs_address = addr;
    @(negedge clk);
    avs_read = 1'b0;
    data     = avs_readdata;
  endtask

  task automatic do_write(input logic [1:0] addr, input logic [31:0] data);
    avs_write     = 1'b1;
    avs_address   = addr;
    avs_writedata = data;
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  logic [31:0] rd;
  logic [3:0]  drain_masks [8] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'hF};

  initial begin
    reset_n = 1'b0; btn_pulse = 4'b0001; avs_address = 2'd0;
    avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    repeat (3) @(negedge clk);
    check("rst_readdata", avs_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);

    // ts is 0 in the first cycle out of reset, so five edges later it is 5.
    reset_n = 1'b1; btn_pulse = 4'b0000;
    repeat (5) @(negedge clk);
    btn_pulse = 4'b0010;
    @(negedge clk);
    btn_pulse = 4'b0000;
    do_read(2'd0, rd); check("data_ts5", rd, 32'h80020005);
    do_read(2'd1, rd); check("status_empty", rd, 32'h00000200);
    @(negedge clk);
    check("readdata_hold", avs_readdata, 32'h00000200);

    btn_pulse = 4'b1001;
    @(negedge clk);
    btn_pulse = 4'b0000;
    do_read(2'd1, rd); check("status_fill1", rd, 32'h00000001);
    do_read(2'd0, rd); check("data_mask09", {16'b0, rd[31:16]}, 32'h00008009);

    // Eleven back-to-back events into an 8-deep FIFO: three are dropped.
    for (int i = 1; i <= 11; i++) begin
      btn_pulse = 4'(i);
      @(negedge clk);
    end
    btn_pulse = 4'b0000;
    do_read(2'd1, rd); check("status_overflow", rd, 32'h00030508);

    avs_read = 1'b1; avs_address = 2'd0; btn_pulse = 4'hF;
    @(negedge clk);
    avs_read = 1'b0; btn_pulse = 4'b0000;
    check("data_first_event", {16'b0, avs_readdata[31:16]}, 32'h00008001);
    do_read(2'd1, rd); check("status_full_pop_push", rd, 32'h00030508);

    for (int i = 0; i < 8; i++) begin
      do_read(2'd0, rd);
      check($sformatf("drain%0d", i), {16'b0, rd[31:16]}, {16'b0, 12'h800, drain_masks[i]});
    end
    do_read(2'd0, rd); check("data_empty", rd, 32'h0);
    do_read(2'd1, rd); check("status_after_drain", rd, 32'h00030300);

    do_write(2'd2, 32'h1);
    do_read(2'd2, rd); check("ctrl_irq_en", rd, 32'h1);
    check("irq_idle", {31'b0, irq}, 32'h0);
    btn_pulse = 4'b0100;
    @(negedge clk);
    btn_pulse = 4'b0000;
    check("irq_after_push", {31'b0, irq}, 32'h1);
    do_read(2'd0, rd);
    check("irq_after_pop", {31'b0, irq}, 32'h0);

    for (int i = 0; i < 3; i++) begin
      btn_pulse = 4'b0001;
      @(negedge clk);
    end
    btn_pulse = 4'b0000;
    check("irq_queued3", {31'b0, irq}, 32'h1);
    do_write(2'd2, 32'h2);
    check("irq_after_flush", {31'b0, irq}, 32'h0);
    do_read(2'd1, rd); check("status_after_flush", rd, 32'h00000200);
    do_read(2'd2, rd); check("ctrl_after_flush", rd, 32'h0);

    // Flush coincident with an event: the event is discarded, not counted as a drop.
    btn_pulse = 4'b1000;
    do_write(2'd2, 32'h2);
    btn_pulse = 4'b0000;
    do_read(2'd1, rd); check("status_flush_vs_event", rd, 32'h00000200);

    do_write(2'd3, 32'h0000FFFF);
    do_write(2'd1, 32'hFFFFFFFF);
    do_read(2'd1, rd); check("status_ignored_writes", rd, 32'h00000200);

    // Timestamp wrap: re-reset so ts is known, then walk it to 0xFFFF.
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (65535) @(negedge clk);
    btn_pulse = 4'b0001;
    @(negedge clk);
    btn_pulse = 4'b0010;
    @(negedge clk);
    btn_pulse = 4'b0000;
    do_read(2'd0, rd); check("data_ts_ffff", rd, 32'h8001FFFF);
    do_read(2'd0, rd); check("data_ts_wrap", rd, 32'h80020000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
